// File: rtl/adder_result_accumulator_if.sv
// Bundle of strobe/result inputs and accumulator/FIFO outputs of adder_result_accumulator.
interface adder_result_accumulator_if #(
  parameter int unsigned ACC_W = 8,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Capture side (driven by the adder stage / pins)
  logic             res_valid;
  logic [3:0]       res_sum;
  logic             res_cout;
  logic             clr;
  logic             rd_en;

  // Result side (driven by the accumulator)
  logic [ACC_W-1:0] acc;
  logic             acc_ovf;
  logic [4:0]       dout;
  logic             dout_valid;
  logic             fifo_full;
  logic             drop;
  logic [CNT_W-1:0] count;

  // Producer / reader of the accumulator
  modport master (
    output res_valid, res_sum, res_cout, clr, rd_en,
    input  acc, acc_ovf, dout, dout_valid, fifo_full, drop, count
  );

  // The accumulator itself
  modport slave (
    input  res_valid, res_sum, res_cout, clr, rd_en,
    output acc, acc_ovf, dout, dout_valid, fifo_full, drop, count
  );

endinterface

// File: rtl/adder_result_accumulator.sv
// Captures {c_out, sum} from the adder stage on a synchronised strobe edge,
// accumulates it with sticky wrap detection and logs it in a FWFT history FIFO.
module adder_result_accumulator #(
  parameter int unsigned ACC_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  adder_result_accumulator_if.slave bus_if
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  // Strobe synchroniser and edge detector
  logic s1_q, s2_q, s3_q;
  logic cap_pulse_c;

  // Capture FSM
  logic [1:0] state_q, state_d;

  // Accumulator and sticky flags
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic             drop_q, drop_d;

  // History FIFO
  logic [4:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Datapath helpers
  logic             capture_c;
  logic [4:0]       v_c;
  logic [SUM_W-1:0] sum_c;
  logic             fifo_full_c;
  logic             pop_c;
  logic             push_c;
  logic             mem_we_c;

  // Two-flop synchroniser on the asynchronous strobe, third flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus_if.res_valid;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign cap_pulse_c = s2_q & ~s3_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: one capture per strobe, HOLD until the strobe drops
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cap_pulse_c) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (s2_q) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!s2_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture value, wide sum and FIFO push/pop qualification
  always_comb begin
    capture_c   = (state_q == ST_CAPTURE);
    v_c         = {bus_if.res_cout, bus_if.res_sum};
    sum_c       = {1'b0, acc_q} + SUM_W'(v_c);
    fifo_full_c = (count_q == CNT_W'(DEPTH));
    pop_c       = bus_if.rd_en && (count_q != '0);
    // A full FIFO still accepts the push when the head leaves in the same cycle
    push_c      = capture_c && (!fifo_full_c || pop_c);
  end

  // Next state of accumulator, flags and FIFO bookkeeping; clr overrides everything
  always_comb begin
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    drop_d    = drop_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_we_c  = 1'b0;

    if (bus_if.clr) begin
      acc_d     = '0;
      acc_ovf_d = 1'b0;
      drop_d    = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end else begin
      if (capture_c) begin
        acc_d = sum_c[ACC_W-1:0];
        if (sum_c[ACC_W]) begin
          acc_ovf_d = 1'b1;
        end
        if (push_c) begin
          mem_we_c = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
          drop_d = 1'b1;
        end
      end

      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Accumulator, flag and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      drop_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      drop_q    <= drop_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage; contents are masked on dout while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_c) begin
      mem_q[wr_ptr_q] <= v_c;
    end
  end

  // Output drive: head word falls through combinationally
  assign bus_if.acc        = acc_q;
  assign bus_if.acc_ovf    = acc_ovf_q;
  assign bus_if.drop       = drop_q;
  assign bus_if.count      = count_q;
  assign bus_if.dout_valid = (count_q != '0);
  assign bus_if.fifo_full  = fifo_full_c;
  assign bus_if.dout       = (count_q != '0) ? mem_q[rd_ptr_q] : 5'd0;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Self-checking bench for adder_result_accumulator: directed scenarios plus
// randomized strobes against a queue-based reference model.
module tb_adder_result_accumulator;

  localparam int unsigned ACC_W = 8;
  localparam int unsigned DEPTH = 4;
  localparam int          ACC_MOD = 1 << ACC_W;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  // Reference model state
  int  m_acc;
  bit  m_ovf;
  bit  m_drop;
  int  m_q[$];

  adder_result_accumulator_if #(.ACC_W(ACC_W), .DEPTH(DEPTH)) bus ();

  adder_result_accumulator #(.ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc  = 0;
    m_ovf  = 1'b0;
    m_drop = 1'b0;
    m_q.delete();
  endtask

  // One clock edge of the behavioural model
  task automatic model_edge(input bit cap, input int v, input bit rd, input bit cl);
    bit full;
    bit pop;
    int s;
    if (cl) begin
      model_reset();
      return;
    end
    full = (m_q.size() == int'(DEPTH));
    pop  = rd && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    if (cap) begin
      s = m_acc + v;
      if (s >= ACC_MOD) m_ovf = 1'b1;
      m_acc = s % ACC_MOD;
      if (!full || pop) m_q.push_back(v);
      else m_drop = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    int exp_dout;
    exp_dout = (m_q.size() > 0) ? m_q[0] : 0;
    check({tag, ".acc"},        32'(bus.acc),        32'(m_acc));
    check({tag, ".acc_ovf"},    32'(bus.acc_ovf),    32'(m_ovf));
    check({tag, ".drop"},       32'(bus.drop),       32'(m_drop));
    check({tag, ".count"},      32'(bus.count),      32'(m_q.size()));
    check({tag, ".dout"},       32'(bus.dout),       32'(exp_dout));
    check({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'(m_q.size() > 0));
    check({tag, ".fifo_full"},  32'(bus.fifo_full),  32'(m_q.size() == int'(DEPTH)));
  endtask

  // Drive one cycle (inputs already set for this cycle), then compare after the edge
  task automatic step(input string tag, input bit cap, input int v, input bit rd, input bit cl);
    bus.rd_en = rd;
    bus.clr   = cl;
    @(posedge clk);
    #1;
    model_edge(cap, v, rd, cl);
    bus.rd_en = 1'b0;
    bus.clr   = 1'b0;
    check_all(tag);
  endtask

  // Raise the strobe for hi edges; the capture edge is the 4th edge after raising it
  task automatic strobe(input string tag, input logic [4:0] v, input int hi, input bit pop, input bit cl);
    bus.res_sum  = v[3:0];
    bus.res_cout = v[4];
    for (int e = 1; e <= hi + 6; e++) begin
      bus.res_valid = (e <= hi);
      step(tag, e == 4, int'(v), pop && (e == 4), cl && (e == 4));
    end
    bus.res_valid = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    model_reset();
    rst_n         = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_sum   = 4'd0;
    bus.res_cout  = 1'b0;
    bus.clr       = 1'b0;
    bus.rd_en     = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset");

    // Single capture of 0x19 then pop
    strobe("single", 5'h19, 1, 1'b0, 1'b0);
    check("single.acc_direct", 32'(bus.acc), 32'h19);
    check("single.dout_direct", 32'(bus.dout), 32'h19);
    step("single_pop", 1'b0, 0, 1'b1, 1'b0);
    check("single_pop.valid_direct", 32'(bus.dout_valid), 32'd0);

    // Stuck strobe captures once, re-raise captures again
    step("clr3", 1'b0, 0, 1'b0, 1'b1);
    strobe("stuck", 5'd3, 20, 1'b0, 1'b0);
    check("stuck.count_direct", 32'(bus.count), 32'd1);
    strobe("reraise", 5'd3, 1, 1'b0, 1'b0);
    check("reraise.acc_direct", 32'(bus.acc), 32'd6);

    // Asynchronous reset in mid-clock clears outputs with no edge
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst");

    // Nine captures of 31: full, drop and wrap
    for (int i = 1; i <= 9; i++) begin
      strobe("ovf", 5'd31, 1, 1'b0, 1'b0);
      if (i == 8) begin
        check("ovf8.acc_direct", 32'(bus.acc), 32'd248);
        check("ovf8.ovf_direct", 32'(bus.acc_ovf), 32'd0);
      end
    end
    check("ovf9.acc_direct", 32'(bus.acc), 32'h17);
    check("ovf9.ovf_direct", 32'(bus.acc_ovf), 32'd1);
    for (int i = 0; i < 5; i++) step("drain", 1'b0, 0, 1'b1, 1'b0);

    // Full FIFO with concurrent pop in the capture cycle
    step("clr5", 1'b0, 0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) strobe("fill", 5'(i), 1, 1'b0, 1'b0);
    strobe("fullpop", 5'd5, 1, 1'b1, 1'b0);
    check("fullpop.count_direct", 32'(bus.count), 32'd4);
    check("fullpop.drop_direct", 32'(bus.drop), 32'd0);
    for (int i = 2; i <= 5; i++) begin
      check("fullpop.order_direct", 32'(bus.dout), 32'(i));
      step("fullpop_rd", 1'b0, 0, 1'b1, 1'b0);
    end

    // clr collides with a capture
    step("clr6", 1'b0, 0, 1'b0, 1'b1);
    strobe("pre40", 5'd31, 1, 1'b0, 1'b0);
    strobe("pre40", 5'd31, 1, 1'b0, 1'b0);
    strobe("pre40", 5'd2, 1, 1'b0, 1'b0);
    check("pre40.acc_direct", 32'(bus.acc), 32'h40);
    strobe("clrcap", 5'd5, 1, 1'b0, 1'b1);
    check("clrcap.acc_direct", 32'(bus.acc), 32'd0);
    strobe("after_clr", 5'd7, 1, 1'b0, 1'b0);
    check("after_clr.acc_direct", 32'(bus.acc), 32'd7);

    // Randomized strobes, pops and clears
    for (int i = 0; i < 60; i++) begin
      logic [4:0] rv;
      rv = 5'($urandom_range(0, 31));
      strobe("rand", rv, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 2) == 0) step("rand_rd", 1'b0, 0, 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
